// File: rtl/rgb_timing_gen.sv
// Video timing generator with test patterns.
// Emits one pixel per valid/ready handshake.
module rgb_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] solid_i,
  input  logic        ready_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o,
  output logic        valid_o,
  output logic        frame_start_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = (H_TOT > 2) ? $clog2(H_TOT) : 1;
  localparam int unsigned VW = (V_TOT > 2) ? $clog2(V_TOT) : 1;

  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [23:0]   solid_q, solid_d;

  logic [31:0] h32;
  logic [31:0] v32;
  logic        h_last;
  logic        v_last;
  logic [2:0]  bar;

  assign h32    = 32'(hcnt_q);
  assign v32    = 32'(vcnt_q);
  assign h_last = (h32 == H_TOT - 1);
  assign v_last = (v32 == V_TOT - 1);
  assign bar    = 3'((h32 * 8) / H_ACTIVE);

  // State, counters and latched pattern; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fcnt_q  <= '0;
      pat_q   <= 2'd3;
      solid_q <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      fcnt_q  <= fcnt_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
    end
  end

  // Next state: counters move on handshakes; frames always complete.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          hcnt_d  = '0;
          vcnt_d  = '0;
          pat_d   = pattern_i;
          solid_d = solid_i;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (h_last) begin
            hcnt_d = '0;
            if (v_last) begin
              vcnt_d  = '0;
              fcnt_d  = fcnt_q + 16'd1;
              pat_d   = pattern_i;
              solid_d = solid_i;
              if (!enable_i) state_d = IDLE;
            end else begin
              vcnt_d = vcnt_q + 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Timing flags and pixel colour from registered values only.
  always_comb begin
    valid_o       = (state_q == RUN);
    vde_o         = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    hsync_o       = (h32 >= HS_BEG) && (h32 < HS_END);
    vsync_o       = (v32 >= VS_BEG) && (v32 < VS_END);
    frame_start_o = valid_o && ready_i && (h32 == 0) && (v32 == 0);
    frame_cnt_o   = fcnt_q;
    r_o           = '0;
    g_o           = '0;
    b_o           = '0;
    if (valid_o && vde_o) begin
      unique case (pat_q)
        2'd0: begin
          r_o = {8{~bar[1]}};
          g_o = {8{~bar[2]}};
          b_o = {8{~bar[0]}};
        end
        2'd1: begin
          r_o = h32[7:0];
          g_o = v32[7:0];
          b_o = 8'(h32 + v32);
        end
        2'd2: {r_o, g_o, b_o} = solid_q;
        2'd3: ;
      endcase
    end
  end

endmodule

// File: doc/rgb_timing_gen.md
RGB_TIMING_GEN -- requirements
Module: rgb_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 88 / 44 / 148, horizontal front porch, sync and back porch in pixels (H_TOT = 2200).
REQ-003 Parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 1080 / 4 / 5 / 36, vertical timing in lines (V_TOT = 1125).
REQ-004 One clock; reset is synchronous and active-high: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-005 enable_i  in  1  request continuous frame generation.
REQ-006 pattern_i  in  2  0 = colour bars, 1 = ramp, 2 = solid colour, 3 = black.
REQ-007 solid_i  in  24  {r,g,b} used by pattern 2.
REQ-008 r_o / g_o / b_o  out  8 each  pixel colour.
REQ-009 hsync_o / vsync_o / vde_o  out  1 each  active-high sync and display-enable.
REQ-010 valid_o  out  1 / ready_i  in  1  stream handshake towards the RGB processing block.
REQ-011 frame_start_o  out  1  one-cycle pulse on the handshake of pixel (0,0).
REQ-012 frame_cnt_o  out  16  completed-frame counter.

Function
REQ-013 State machine with two states: IDLE (valid_o = 0) and RUN (valid_o = 1).
REQ-014 IDLE -> RUN when enable_i = 1 is sampled; counters hcnt = 0 and vcnt = 0; first valid_o one cycle after enable_i is sampled.
REQ-015 In RUN, hcnt/vcnt advance only on handshake (valid_o && ready_i); hcnt wraps at H_TOT-1 to 0 and increments vcnt; vcnt wraps at V_TOT-1 to 0.
REQ-016 On handshake of pixel (H_TOT-1, V_TOT-1): frame_cnt_o increments (wraps at 0xFFFF to 0); stays in RUN if enable_i = 1, else goes to IDLE. enable_i deassertion mid-frame never truncates a frame.
REQ-017 All outputs are a function of registered counter, state and latched-pattern values only; data and meta stay stable while valid_o = 1 and ready_i = 0.
REQ-018 vde_o = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
REQ-019 hsync_o = 1 for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, on every line.
REQ-020 vsync_o = 1 for all pixels of lines V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
REQ-021 pattern_i and solid_i are latched on entry to RUN and on the handshake of pixel (H_TOT-1, V_TOT-1); mid-frame changes take effect at the next frame.
REQ-022 r_o/g_o/b_o = 0 whenever vde_o = 0 or valid_o = 0.
REQ-023 Colour bars: bar = (hcnt*8)/H_ACTIVE, 0..7 = white, yellow, cyan, green, magenta, red, blue, black. Full-scale channel value is 0xFF.
REQ-024 Ramp: r = hcnt[7:0], g = vcnt[7:0], b = (hcnt+vcnt)[7:0], truncated modulo 256.
REQ-025 Solid: {r_o,g_o,b_o} = latched solid_i. Black: all channels 0.
REQ-026 frame_start_o = 1 only in the cycle of the handshake at hcnt = 0, vcnt = 0.

Reset
REQ-027 rst_i = 1 at a clock edge forces IDLE, hcnt = vcnt = 0, frame_cnt_o = 0, latched pattern = 3 (black), valid_o = 0, frame_start_o = 0.
REQ-028 rst_i = 1 during RUN aborts the frame immediately. No partial-frame completion occurs and frame_cnt_o does not increment.
REQ-029 rst_i has priority over all other inputs.

Verification
Common settings: H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 1 (H_TOT = 12); V_ACTIVE = 4, V_FP/V_SYNC/V_BP = 1 (V_TOT = 7); 84 pixels per frame.
REQ-030 Scenario 1: enable_i = 1, ready_i = 1 constantly, pattern 0 -> frame_start_o pulses every 84 cycles. hsync_o is high at hcnt 9-10. vsync_o is high on line 5. vde_o is high for 32 pixels per frame. Bars are 1 pixel wide: FFFFFF, FFFF00, 00FFFF, ...
REQ-031 Scenario 2: random ready_i (50 %) -> no output change while stalled. Sequence is identical to scenario 1 after removing non-handshake cycles.
REQ-032 Scenario 3: enable_i dropped at pixel 20 of frame 0 -> all 84 pixels of frame 0 are emitted, then valid_o = 0 and frame_cnt_o = 1.
REQ-033 Scenario 4: pattern_i switched from 2 (solid_i = 0x123456) to 1 mid-frame -> remaining active pixels stay 0x123456. The next frame is a ramp, with pixel (3,2) = {03,02,05}.
REQ-034 Scenario 5: rst_i pulsed at pixel 40, then enable_i held high -> valid_o = 0 the cycle after reset. Restart is at (0,0) with frame_start_o pulsing and frame_cnt_o = 0.
